// File: rtl/ub_pkg.sv
// Shared definitions for the unified buffer: default geometry, burst FSM states
// and an elaboration-time clog2 helper.
package ub_pkg;

  localparam int unsigned UB_LANES  = 16;
  localparam int unsigned UB_LANE_W = 8;
  localparam int unsigned UB_DEPTH  = 256;

  typedef enum logic {
    UB_IDLE  = 1'b0,
    UB_BURST = 1'b1
  } ub_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/ub_sdp_mem.sv
// Masked-write, registered-read simple-dual-port array. No reset so it maps to block RAM;
// a read in the same cycle as a write to the same address returns the old contents.
module ub_sdp_mem #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = 8
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [LANES-1:0]        wr_mask,
  input  logic [LANES*LANE_W-1:0] wr_data,
  input  logic                    rd_en,
  input  logic [AW-1:0]           rd_addr,
  output logic [LANES*LANE_W-1:0] rd_data
);

  logic [LANES*LANE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wr_mask[i]) mem[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
      end
    end
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/unified_buffer_sdp_v2.sv
// Unified buffer top: burst-read FSM, collision forwarding and the RL-deep
// valid/last/data return pipeline around the ub_sdp_mem array.
module unified_buffer_sdp_v2
  import ub_pkg::*;
#(
  parameter  int unsigned LANES     = UB_LANES,
  parameter  int unsigned LANE_W    = UB_LANE_W,
  parameter  int unsigned DEPTH     = UB_DEPTH,
  parameter  int unsigned OUT_REG   = 0,
  parameter  int unsigned WR_BYPASS = 1,
  localparam int unsigned DW        = LANES * LANE_W,
  localparam int unsigned AW        = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [LANES-1:0] wr_mask,
  input  logic [DW-1:0]    wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic             burst_start,
  input  logic [AW-1:0]    burst_base,
  input  logic [AW:0]      burst_len,
  output logic             burst_busy,
  output logic [DW-1:0]    rd_data,
  output logic             rd_valid,
  output logic             rd_last
);

  ub_state_t     state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic [AW:0]   beats, beats_nx;
  logic          iss_v, iss_last;
  logic [AW-1:0] iss_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= UB_IDLE;
      cnt   <= '0;
      beats <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      beats <= beats_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    beats_nx = beats;
    iss_v    = 1'b0;
    iss_last = 1'b0;
    iss_addr = rd_addr;
    case (state)
      UB_IDLE: begin
        if (burst_start && (burst_len != '0)) begin
          state_nx = UB_BURST;
          cnt_nx   = burst_base;
          beats_nx = burst_len;
        end else if (rd_en) begin
          iss_v    = 1'b1;
          iss_last = 1'b1;
        end
      end
      UB_BURST: begin
        iss_v    = 1'b1;
        iss_addr = cnt;
        cnt_nx   = cnt + 1'b1;
        beats_nx = beats - 1'b1;
        if (beats == {{AW{1'b0}}, 1'b1}) begin
          iss_last = 1'b1;
          state_nx = UB_IDLE;
        end
      end
      default: state_nx = UB_IDLE;
    endcase
  end

  assign burst_busy = (state == UB_BURST);

  logic [DW-1:0] mem_q;

  ub_sdp_mem #(
    .LANES (LANES),
    .LANE_W(LANE_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_mask(wr_mask),
    .wr_data(wr_data),
    .rd_en  (iss_v),
    .rd_addr(iss_addr),
    .rd_data(mem_q)
  );

  // Forwarding lanes are captured alongside the read so the merge lines up with mem_q.
  logic [LANES-1:0] byp_mask;
  logic [DW-1:0]    byp_data;

  always_ff @(posedge clk) begin
    if (iss_v) begin
      byp_mask <= ((WR_BYPASS != 0) && wr_en && (wr_addr == iss_addr)) ? wr_mask : '0;
      byp_data <= wr_data;
    end
  end

  logic [DW-1:0] merged;

  always_comb begin
    merged = mem_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (byp_mask[i]) merged[i*LANE_W +: LANE_W] = byp_data[i*LANE_W +: LANE_W];
    end
  end

  logic v1, last1, seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      last1 <= 1'b0;
      seen  <= 1'b0;
    end else begin
      v1    <= iss_v;
      last1 <= iss_v && iss_last;
      seen  <= seen || v1;
    end
  end

  generate
    if (OUT_REG == 0) begin : g_direct
      // The RAM output is not resettable; gate it to zero until the first read returns.
      assign rd_valid = v1;
      assign rd_last  = last1;
      assign rd_data  = (seen || v1) ? merged : '0;
    end else begin : g_outreg
      logic          v2, last2;
      logic [DW-1:0] data2;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v2    <= 1'b0;
          last2 <= 1'b0;
          data2 <= '0;
        end else begin
          v2    <= v1;
          last2 <= last1;
          if (v1) data2 <= merged;
        end
      end
      assign rd_valid = v2;
      assign rd_last  = last2;
      assign rd_data  = data2;
    end
  endgenerate

endmodule

// File: doc/unified_buffer_sdp_v2.md
Name: unified_buffer_sdp_v2

Overview:
- Parametrised simple-dual-port unified buffer for the systolic-array datapath, clocked on the rising edge of clk.
- One write port with per-lane write mask.
- One read port with two modes: single-word read, or burst read from an internal address counter, with read-valid and last-beat tracking.
- Sits between the host/DMA write side and the array input feeders; replaces the fixed 256x16x8b buffer.

Parameters:
- LANES, 16, number of data lanes per word.
- LANE_W, 8, bits per lane; word width DW = LANES*LANE_W.
- DEPTH, 256, words; must be a power of 2 and at least 2; AW = clog2(DEPTH).
- OUT_REG, 0, 1 adds an output register stage; read latency RL = 1 + OUT_REG.
- WR_BYPASS, 1, 1 = write-first forwarding on a same-cycle address collision; 0 = read-first (old data).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_mask  in  LANES  per-lane write enable; lane i covers wr_data[i*LANE_W +: LANE_W].
- wr_data  in  DW  write data.
- rd_en  in  1  single-word read request.
- rd_addr  in  AW  single-read address.
- burst_start  in  1  starts a burst read.
- burst_base  in  AW  burst start address.
- burst_len  in  AW+1  beats, valid range 1..DEPTH.
- burst_busy  out  1  burst in progress (IDLE = 0).
- rd_data  out  DW  read data.
- rd_valid  out  1  rd_data valid this cycle.
- rd_last  out  1  final beat of a burst, or any single read.

Behaviour:
- Reset (async assert, sync release): rd_data=0, rd_valid=0, rd_last=0, burst_busy=0, FSM=IDLE, addr counter=0, beat counter=0, valid/last pipeline cleared. Memory array is NOT reset; contents are undefined until written.
- Write: on posedge with wr_en=1, each lane with wr_mask[i]=1 is updated; masked-off lanes keep their value. wr_en=1 with wr_mask=0 is a no-op. Write is never blocked by reads or bursts.
- Read issue: at most one memory read per cycle. The issued address is rd_addr (single) or the counter (burst). Data appears RL cycles after issue with rd_valid=1.
- Collision (read address == wr_addr, same cycle, wr_en=1):
  - WR_BYPASS=1: lanes with mask=1 return wr_data; other lanes return stored data.
  - WR_BYPASS=0: all lanes return old stored data.
- FSM states:
  - IDLE: burst_start=1 and burst_len!=0 -> load counter=burst_base, beats=burst_len, go to BURST, burst_busy=1 from the next cycle. burst_len=0 -> ignored, no beats.
  - BURST: issue a read each cycle at counter; counter increments modulo DEPTH (DEPTH-1 wraps to 0); beats decrements. When beats==1, issue the last beat tagged last and return to IDLE. burst_busy drops the cycle after the last issue.
- Priority:
  - burst_start and rd_en in the same IDLE cycle: burst wins, rd_en is dropped.
  - rd_en and burst_start while in BURST: ignored, no queueing.
- Throughput: back-to-back bursts need 1 idle cycle (burst_busy low) between them. A single read can issue on the cycle burst_busy is low.
- Output timing: rd_last is coincident with rd_valid. rd_data holds its last value while rd_valid=0.
- Reset mid-burst: the burst is aborted, and no further rd_valid pulses come from in-flight reads.

Decomposition:
- Shared package ub_pkg: clog2 function, FSM state encoding (UB_IDLE, UB_BURST), default LANES/LANE_W/DEPTH constants.
- One sub-module, ub_sdp_mem: masked-write/registered-read memory array with no reset, so it can infer block RAM.
- Top level holds the FSM, counters, collision bypass and the RL-deep valid/last/data pipeline.

Test Plan:
- Masked write: write addr 5 = all 0xAA, then addr 5 data 0x55, mask 0x00FF; single read addr 5 -> after RL cycles rd_data lanes 0-7 = 0x55, lanes 8-15 = 0xAA, rd_valid=1, rd_last=1 for one cycle.
- Burst wrap: fill addr i with value i; burst base 254, len 4 (DEPTH=256) -> beats return 254, 255, 0, 1 on consecutive cycles; rd_last only on the beat returning 1; burst_busy high 4 cycles.
- Collision: same cycle write addr 7 = 0x11 (full mask) and read addr 7 (old 0x22) -> 0x11 with WR_BYPASS=1, 0x22 with WR_BYPASS=0.
- Priority: during a burst, pulse rd_en and burst_start -> neither is accepted, beat count unchanged. In IDLE, assert both together -> only burst beats appear. burst_len=0 -> no rd_valid and burst_busy stays 0.
- Reset mid-burst: start burst len 16, drop rst_n at beat 3 -> all outputs 0 immediately; after release, no stray rd_valid; the next single read works.
- Latency: repeat the burst test with OUT_REG=1 -> identical data sequence shifted one cycle later.
